rs_alu: RTL and testbench
=========================

RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 Parameter DEPTH, default 4, number of station entries (2..8).
REQ-002 Parameter XLEN, default 32, operand width.
REQ-003 Parameter TAG_W, default 4, producer tag width.
REQ-004 Parameter OP_W, default 5, ALU control width.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  synchronous kill of all held and outgoing uops.
REQ-008 disp_en  input  1  dispatch strobe from issue logic (disp_en_alu).
REQ-009 disp_op  input  OP_W  ALU operation.
REQ-010 disp_rd_tag  input  TAG_W  destination tag.
REQ-011 disp_src1_rdy, disp_src2_rdy  input  1 each  operand value already valid.
REQ-012 disp_src1_val, disp_src2_val  input  XLEN each  operand value, used when rdy=1.
REQ-013 disp_src1_tag, disp_src2_tag  input  TAG_W each  producer tag, used when rdy=0.
REQ-014 cdb_valid  input  1; cdb_tag  input  TAG_W; cdb_data  input  XLEN  result broadcast.
REQ-015 rs_full  output  1  all DEPTH entries valid (feeds rs_alu_full).
REQ-016 ex_valid  output  1; ex_ready  input  1  valid/ready handshake to ALU.
REQ-017 ex_op  output  OP_W; ex_src1, ex_src2  output  XLEN; ex_rd_tag  output  TAG_W  issued uop.

Function
REQ-018 Each entry holds valid, op, rd_tag, per-source rdy/tag/value; an entry is ready when valid and both sources rdy.
REQ-019 disp_en with rs_full=0 writes the lowest-index invalid entry at the next edge; disp_en with rs_full=1 is ignored (no state change).
REQ-020 rs_full is a combinational function of registered entry valids only; an entry freed in the same cycle does not clear rs_full until the following cycle.
REQ-021 Wakeup: cdb_valid with cdb_tag equal to a not-rdy source tag of a valid entry sets that source rdy and captures cdb_data at the edge; all matching entries/sources update simultaneously.
REQ-022 Dispatch bypass: a not-rdy dispatched source whose tag matches a same-cycle CDB broadcast is written rdy with cdb_data.
REQ-023 ex_* is a registered output stage; it loads a selected ready entry when ex_valid=0 or (ex_valid=1 and ex_ready=1); otherwise it holds all ex_* stable.
REQ-024 The entry loaded into the output stage is invalidated at the same edge; at most one entry leaves per cycle.
REQ-025 Minimum latency: a uop dispatched fully ready at edge E0 shows ex_valid=1 after edge E1.
REQ-026 Output load with no ready entry and handshake completing clears ex_valid.
REQ-027 A newly dispatched entry is not selectable in its dispatch cycle.
REQ-028 flush clears all entry valids and ex_valid at the next edge, overriding dispatch, wakeup and output load that cycle.

Reset
REQ-029 rst_n=0 immediately clears all entry valid bits, ex_valid, rs_full and zeroes ex_op, ex_src1, ex_src2, ex_rd_tag.
REQ-030 Deassertion mid-operation leaves the block empty; no uop held before reset is ever issued.

Configuration
REQ-031 Macro RS_ALU_OLDEST_FIRST_EN defined: per-entry age counters (reset 0, entries aged on each dispatch) select the oldest ready entry.
REQ-032 RS_ALU_OLDEST_FIRST_EN undefined: lowest-index ready entry is selected; no age state is built.

Verification
REQ-033 Dispatch op=5, src1=0x10 rdy, src2=0x20 rdy, ex_ready=1 -> ex_valid=1 one edge later with ex_src1=0x10, ex_src2=0x20, ex_op=5.
REQ-034 Dispatch 4 uops with src1 tag=3 not rdy (DEPTH=4) -> rs_full=1, fifth disp_en dropped; cdb tag=3 data=0xAA -> all four issue, one per cycle, ex_src1=0xAA.
REQ-035 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, no entry consumed; ex_ready=1 -> next ready uop loaded same edge.
REQ-036 Dispatch src2 tag=7 not rdy in same cycle as cdb tag=7 data=0x55 -> entry issues with ex_src2=0x55, no further wakeup needed.
REQ-037 flush with 3 valid entries and ex_valid=1 plus concurrent disp_en -> next cycle ex_valid=0, rs_full=0, nothing issued; with RS_ALU_OLDEST_FIRST_EN, entries 2 then 0 woken same cycle, 2 dispatched first -> entry 2 issues first.

Source files
------------

// File: rtl/rs_alu.sv
// ALU reservation station: tag wakeup, dispatch bypass, registered issue.
// Define RS_ALU_OLDEST_FIRST_EN to issue the oldest ready entry first.
module rs_alu #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int TAG_W = 4,
   parameter int OP_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             disp_en,
   input  logic [OP_W-1:0]  disp_op,
   input  logic [TAG_W-1:0] disp_rd_tag,
   input  logic             disp_src1_rdy,
   input  logic             disp_src2_rdy,
   input  logic [XLEN-1:0]  disp_src1_val,
   input  logic [XLEN-1:0]  disp_src2_val,
   input  logic [TAG_W-1:0] disp_src1_tag,
   input  logic [TAG_W-1:0] disp_src2_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]  cdb_data,
   output logic             rs_full,
   output logic             ex_valid,
   input  logic             ex_ready,
   output logic [OP_W-1:0]  ex_op,
   output logic [XLEN-1:0]  ex_src1,
   output logic [XLEN-1:0]  ex_src2,
   output logic [TAG_W-1:0] ex_rd_tag
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] e_valid;
   logic [DEPTH-1:0] e_rdy1;
   logic [DEPTH-1:0] e_rdy2;
   logic [OP_W-1:0]  e_op   [DEPTH];
   logic [TAG_W-1:0] e_rd   [DEPTH];
   logic [TAG_W-1:0] e_tag1 [DEPTH];
   logic [TAG_W-1:0] e_tag2 [DEPTH];
   logic [XLEN-1:0]  e_val1 [DEPTH];
   logic [XLEN-1:0]  e_val2 [DEPTH];

`ifdef RS_ALU_OLDEST_FIRST_EN
   localparam int AW = IW + 2;
   logic [AW-1:0] age [DEPTH];
   logic [AW-1:0] best_age;
`endif

   logic [DEPTH-1:0] ready;
   logic [IW-1:0]    sel;
   logic             any_ready;
   logic [IW-1:0]    free_idx;
   logic             disp_acc;
   logic             load;
   logic             byp1;
   logic             byp2;

   assign rs_full  = &e_valid;
   assign ready    = e_valid & e_rdy1 & e_rdy2;
   assign disp_acc = disp_en & ~rs_full;
   assign load     = ~ex_valid | ex_ready;
   assign byp1     = cdb_valid & (cdb_tag == disp_src1_tag);
   assign byp2     = cdb_valid & (cdb_tag == disp_src2_tag);

   // Lowest-index empty slot receives the next dispatch.
   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!e_valid[i]) free_idx = IW'(i);
      end
   end

`ifdef RS_ALU_OLDEST_FIRST_EN
   // Pick the ready entry with the largest age; ties go to lowest index.
   always_comb begin
      sel       = '0;
      any_ready = 1'b0;
      best_age  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && (!any_ready || age[i] > best_age)) begin
            sel       = IW'(i);
            any_ready = 1'b1;
            best_age  = age[i];
         end
      end
   end

   // Ages count dispatches seen since the entry arrived, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      end else if (!flush && disp_acc) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (free_idx == IW'(i)) age[i] <= '0;
            else if (e_valid[i] && age[i] != '1) age[i] <= age[i] + 1'b1;
         end
      end
   end
`else
   // Pick the lowest-index ready entry.
   always_comb begin
      sel       = '0;
      any_ready = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ready[i]) begin
            sel       = IW'(i);
            any_ready = 1'b1;
         end
      end
   end
`endif

   // Entry storage: dispatch write, CDB wakeup, release on issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid <= '0;
         e_rdy1  <= '0;
         e_rdy2  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            e_op[i]   <= '0;
            e_rd[i]   <= '0;
            e_tag1[i] <= '0;
            e_tag2[i] <= '0;
            e_val1[i] <= '0;
            e_val2[i] <= '0;
         end
      end else if (flush) begin
         e_valid <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (disp_acc && free_idx == IW'(i)) begin
               e_valid[i] <= 1'b1;
               e_op[i]    <= disp_op;
               e_rd[i]    <= disp_rd_tag;
               e_tag1[i]  <= disp_src1_tag;
               e_tag2[i]  <= disp_src2_tag;
               e_rdy1[i]  <= disp_src1_rdy | byp1;
               e_rdy2[i]  <= disp_src2_rdy | byp2;
               e_val1[i]  <= disp_src1_rdy ? disp_src1_val : cdb_data;
               e_val2[i]  <= disp_src2_rdy ? disp_src2_val : cdb_data;
            end else if (e_valid[i]) begin
               if (cdb_valid && !e_rdy1[i] && cdb_tag == e_tag1[i]) begin
                  e_rdy1[i] <= 1'b1;
                  e_val1[i] <= cdb_data;
               end
               if (cdb_valid && !e_rdy2[i] && cdb_tag == e_tag2[i]) begin
                  e_rdy2[i] <= 1'b1;
                  e_val2[i] <= cdb_data;
               end
            end
            if (load && any_ready && sel == IW'(i)) e_valid[i] <= 1'b0;
         end
      end
   end

   // Registered issue stage; holds stable while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid  <= 1'b0;
         ex_op     <= '0;
         ex_src1   <= '0;
         ex_src2   <= '0;
         ex_rd_tag <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (load) begin
         ex_valid <= any_ready;
         if (any_ready) begin
            ex_op     <= e_op[sel];
            ex_src1   <= e_val1[sel];
            ex_src2   <= e_val2[sel];
            ex_rd_tag <= e_rd[sel];
         end
      end
   end

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: issue, full, stall, bypass, flush, reset.
// Oldest-first ordering is checked when RS_ALU_OLDEST_FIRST_EN is defined.
module tb_rs_alu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        disp_en = 1'b0;
   logic [4:0]  disp_op = '0;
   logic [3:0]  disp_rd_tag = '0;
   logic        disp_src1_rdy = 1'b0;
   logic        disp_src2_rdy = 1'b0;
   logic [31:0] disp_src1_val = '0;
   logic [31:0] disp_src2_val = '0;
   logic [3:0]  disp_src1_tag = '0;
   logic [3:0]  disp_src2_tag = '0;
   logic        cdb_valid = 1'b0;
   logic [3:0]  cdb_tag = '0;
   logic [31:0] cdb_data = '0;
   logic        rs_full;
   logic        ex_valid;
   logic        ex_ready = 1'b0;
   logic [4:0]  ex_op;
   logic [31:0] ex_src1;
   logic [31:0] ex_src2;
   logic [3:0]  ex_rd_tag;

   int checks = 0;
   int errors = 0;

   rs_alu dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .disp_en(disp_en), .disp_op(disp_op),
      .disp_rd_tag(disp_rd_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
      .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rs_full(rs_full), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_op(ex_op), .ex_src1(ex_src1), .ex_src2(ex_src2),
      .ex_rd_tag(ex_rd_tag)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      disp_en   = 1'b0;
      cdb_valid = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic disp(input logic [4:0] op, input logic [3:0] rd,
                       input logic r1, input logic [31:0] v1,
                       input logic [3:0] t1, input logic r2,
                       input logic [31:0] v2, input logic [3:0] t2);
      disp_en       = 1'b1;
      disp_op       = op;
      disp_rd_tag   = rd;
      disp_src1_rdy = r1;
      disp_src1_val = v1;
      disp_src1_tag = t1;
      disp_src2_rdy = r2;
      disp_src2_val = v2;
      disp_src2_tag = t2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if (ex_valid !== 1'b0) begin errors++;
         $display("FAIL rst_ex_valid got %0b exp 0", ex_valid); end
      checks++;
      if (rs_full !== 1'b0) begin errors++;
         $display("FAIL rst_rs_full got %0b exp 0", rs_full); end
      checks++;
      if ({ex_op, ex_src1, ex_src2, ex_rd_tag} !== '0) begin errors++;
         $display("FAIL rst_ex_data got %0h/%0h/%0h/%0h exp 0",
                  ex_op, ex_src1, ex_src2, ex_rd_tag); end
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      ex_ready = 1'b1;
      disp(5'd5, 4'd1, 1'b1, 32'h10, 4'd0, 1'b1, 32'h20, 4'd0);
      step();
      idle();
      checks++;
      if (ex_valid !== 1'b0) begin errors++;
         $display("FAIL basic_same_cycle got %0b exp 0", ex_valid); end
      step();
      checks++;
      if (ex_valid !== 1'b1 || ex_op !== 5'd5 || ex_rd_tag !== 4'd1)
         begin errors++;
         $display("FAIL basic_issue got v=%0b op=%0d rd=%0d exp 1/5/1",
                  ex_valid, ex_op, ex_rd_tag); end
      checks++;
      if (ex_src1 !== 32'h10 || ex_src2 !== 32'h20) begin errors++;
         $display("FAIL basic_srcs got %0h/%0h exp 10/20",
                  ex_src1, ex_src2); end
      step();
      checks++;
      if (ex_valid !== 1'b0) begin errors++;
         $display("FAIL basic_drain got %0b exp 0", ex_valid); end
   endtask

   task automatic test_full();
      ex_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         disp(5'd2, 4'(i), 1'b0, 32'h0, 4'd3,
              1'b1, 32'h100 + i, 4'd0);
         step();
      end
      checks++;
      if (rs_full !== 1'b1) begin errors++;
         $display("FAIL full_set got %0b exp 1", rs_full); end
      disp(5'd9, 4'd9, 1'b1, 32'h99, 4'd0, 1'b1, 32'h99, 4'd0);
      step();
      idle();
      step();
      checks++;
      if (ex_valid !== 1'b0 || rs_full !== 1'b1) begin errors++;
         $display("FAIL full_drop got v=%0b full=%0b exp 0/1",
                  ex_valid, rs_full); end
      cdb_valid = 1'b1;
      cdb_tag   = 4'd3;
      cdb_data  = 32'hAA;
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (ex_valid !== 1'b1 || ex_rd_tag !== 4'(i) ||
             ex_src1 !== 32'hAA || ex_src2 !== 32'h100 + i) begin
            errors++;
            $display("FAIL full_issue%0d got v=%0b rd=%0d s1=%0h s2=%0h",
                     i, ex_valid, ex_rd_tag, ex_src1, ex_src2);
         end
      end
      checks++;
      if (rs_full !== 1'b0) begin errors++;
         $display("FAIL full_clear got %0b exp 0", rs_full); end
      step();
      checks++;
      if (ex_valid !== 1'b0) begin errors++;
         $display("FAIL full_fifth_leak got %0b rd=%0d exp 0",
                  ex_valid, ex_rd_tag); end
   endtask

   task automatic test_stall();
      ex_ready = 1'b0;
      disp(5'd1, 4'd4, 1'b1, 32'h1, 4'd0, 1'b1, 32'h11, 4'd0);
      step();
      disp(5'd3, 4'd5, 1'b1, 32'h2, 4'd0, 1'b1, 32'h22, 4'd0);
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (ex_valid !== 1'b1 || ex_rd_tag !== 4'd4 ||
             ex_src1 !== 32'h1 || ex_op !== 5'd1) begin
            errors++;
            $display("FAIL stall_hold%0d got v=%0b rd=%0d s1=%0h op=%0d",
                     i, ex_valid, ex_rd_tag, ex_src1, ex_op);
         end
      end
      ex_ready = 1'b1;
      step();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd_tag !== 4'd5 ||
          ex_src2 !== 32'h22) begin errors++;
         $display("FAIL stall_next got v=%0b rd=%0d s2=%0h exp 1/5/22",
                  ex_valid, ex_rd_tag, ex_src2); end
      step();
      checks++;
      if (ex_valid !== 1'b0) begin errors++;
         $display("FAIL stall_drain got %0b exp 0", ex_valid); end
   endtask

   task automatic test_bypass();
      ex_ready = 1'b1;
      disp(5'd7, 4'd6, 1'b1, 32'h3, 4'd0, 1'b0, 32'h0, 4'd7);
      cdb_valid = 1'b1;
      cdb_tag   = 4'd7;
      cdb_data  = 32'h55;
      step();
      idle();
      step();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd_tag !== 4'd6 ||
          ex_src2 !== 32'h55 || ex_src1 !== 32'h3) begin errors++;
         $display("FAIL bypass got v=%0b rd=%0d s1=%0h s2=%0h",
                  ex_valid, ex_rd_tag, ex_src1, ex_src2); end
      step();
   endtask

   task automatic test_flush();
      ex_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         disp(5'd4, 4'(8 + i), 1'b1, 32'h40 + i, 4'd0,
              1'b1, 32'h0, 4'd0);
         step();
      end
      idle();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd_tag !== 4'd8) begin errors++;
         $display("FAIL flush_pre got v=%0b rd=%0d exp 1/8",
                  ex_valid, ex_rd_tag); end
      ex_ready = 1'b1;
      flush    = 1'b1;
      disp(5'd6, 4'd15, 1'b1, 32'h77, 4'd0, 1'b1, 32'h77, 4'd0);
      step();
      idle();
      checks++;
      if (ex_valid !== 1'b0 || rs_full !== 1'b0) begin errors++;
         $display("FAIL flush_now got v=%0b full=%0b exp 0/0",
                  ex_valid, rs_full); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (ex_valid !== 1'b0) begin errors++;
            $display("FAIL flush_leak%0d got rd=%0d exp none",
                     i, ex_rd_tag); end
      end
   endtask

   task automatic test_reset_mid();
      ex_ready = 1'b0;
      disp(5'd2, 4'd2, 1'b1, 32'h5, 4'd0, 1'b1, 32'h6, 4'd0);
      step();
      disp(5'd2, 4'd3, 1'b1, 32'h7, 4'd0, 1'b1, 32'h8, 4'd0);
      step();
      idle();
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ex_valid !== 1'b0 || ex_src1 !== '0 || ex_rd_tag !== '0)
         begin errors++;
         $display("FAIL rstmid_async got v=%0b s1=%0h rd=%0d exp 0",
                  ex_valid, ex_src1, ex_rd_tag); end
      step();
      rst_n    = 1'b1;
      ex_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (ex_valid !== 1'b0) begin errors++;
            $display("FAIL rstmid_leak%0d got rd=%0d exp none",
                     i, ex_rd_tag); end
      end
   endtask

`ifdef RS_ALU_OLDEST_FIRST_EN
   task automatic test_oldest();
      ex_ready = 1'b1;
      disp(5'd1, 4'd10, 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, 4'd0);
      step();
      disp(5'd1, 4'd11, 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, 4'd0);
      step();
      disp(5'd1, 4'd12, 1'b0, 32'h0, 4'd8, 1'b1, 32'h0, 4'd0);
      step();
      idle();
      cdb_valid = 1'b1;
      cdb_tag   = 4'd9;
      step();
      idle();
      step();
      step();
      disp(5'd1, 4'd13, 1'b0, 32'h0, 4'd8, 1'b1, 32'h0, 4'd0);
      step();
      idle();
      cdb_valid = 1'b1;
      cdb_tag   = 4'd8;
      step();
      idle();
      step();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd_tag !== 4'd12) begin errors++;
         $display("FAIL oldest_first got v=%0b rd=%0d exp 1/12",
                  ex_valid, ex_rd_tag); end
      step();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd_tag !== 4'd13) begin errors++;
         $display("FAIL oldest_second got v=%0b rd=%0d exp 1/13",
                  ex_valid, ex_rd_tag); end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_stall();
      test_bypass();
      test_flush();
      test_reset_mid();
`ifdef RS_ALU_OLDEST_FIRST_EN
      test_oldest();
`endif
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
